// File: rtl/volatility_rd_ctrl_if.sv
// ---------------------------------------------------------------------------
// volatility_rd_ctrl_if
// Bundles the signals between the volatility read controller, the buffer
// write stream, the buffer RAM read port and the request/result side.
//
// Signals (names follow the controller's port list):
//   i_wr_valid / i_wr_stock_id      write-stream observation (fill tracking)
//   i_req / i_req_stock_id          single-cycle window read request
//   o_busy                          sweep in progress
//   o_rd_en / o_rd_addr / i_rd_data RAM read port, 1-cycle read latency
//   o_done / o_count / o_sum /
//   o_sum_sq                        window results, valid on o_done
//
// Modports:
//   slave  - the controller itself
//   master - the environment around it (writer, RAM, requester)
// ---------------------------------------------------------------------------
interface volatility_rd_ctrl_if #(
    parameter int NUM_STOCKS  = 4,
    parameter int BUFFER_SIZE = 20,
    parameter int DATA_WIDTH  = 32
);
    localparam int SW = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;
    localparam int AW = $clog2(NUM_STOCKS * BUFFER_SIZE);
    localparam int CW = $clog2(BUFFER_SIZE + 1);

    logic                      i_wr_valid;
    logic [SW-1:0]             i_wr_stock_id;
    logic                      i_req;
    logic [SW-1:0]             i_req_stock_id;
    logic                      o_busy;
    logic                      o_rd_en;
    logic [AW-1:0]             o_rd_addr;
    logic [DATA_WIDTH-1:0]     i_rd_data;
    logic                      o_done;
    logic [CW-1:0]             o_count;
    logic [DATA_WIDTH+CW-1:0]  o_sum;
    logic [2*DATA_WIDTH+CW-1:0] o_sum_sq;

    modport slave (
        input  i_wr_valid, i_wr_stock_id, i_req, i_req_stock_id, i_rd_data,
        output o_busy, o_rd_en, o_rd_addr, o_done, o_count, o_sum, o_sum_sq
    );

    modport master (
        output i_wr_valid, i_wr_stock_id, i_req, i_req_stock_id, i_rd_data,
        input  o_busy, o_rd_en, o_rd_addr, o_done, o_count, o_sum, o_sum_sq
    );
endinterface

// File: rtl/volatility_rd_ctrl.sv
// ---------------------------------------------------------------------------
// volatility_rd_ctrl
// Read-side controller for the per-stock volatility buffer. Counts valid
// samples per stock by watching the write stream, and on request sweeps
// offsets 0..fill-1 of that stock's region through a 1-cycle-latency RAM
// port, accumulating sum and sum of squares for the variance stage.
//
// Ports:
//   i_clk      clock, all logic on posedge
//   i_reset_n  synchronous active-low reset
//   bus        volatility_rd_ctrl_if.slave (write observation, request,
//              RAM read port, results)
// ---------------------------------------------------------------------------
module volatility_rd_ctrl #(
    parameter int NUM_STOCKS  = 4,
    parameter int BUFFER_SIZE = 20,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    volatility_rd_ctrl_if.slave  bus
);
    localparam int SW    = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;
    localparam int AW    = $clog2(NUM_STOCKS * BUFFER_SIZE);
    localparam int CW    = $clog2(BUFFER_SIZE + 1);
    localparam int SUM_W = DATA_WIDTH + CW;
    localparam int SQ_W  = 2 * DATA_WIDTH + CW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Fill tracking: fill_d holds each stock's count including this
    // cycle's write, so a request snapshot sees a same-cycle write.
    // ------------------------------------------------------------------
    logic [CW-1:0] fill_d [NUM_STOCKS];

    generate
        for (genvar gi = 0; gi < NUM_STOCKS; gi++) begin : gen_fill
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          hit;

            assign hit   = bus.i_wr_valid && (bus.i_wr_stock_id == SW'(gi));
            assign cnt_d = (hit && (cnt_q != CW'(BUFFER_SIZE))) ? cnt_q + CW'(1) : cnt_q;

            always_ff @(posedge i_clk) begin
                if (!i_reset_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign fill_d[gi] = cnt_d;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Request snapshot. The id is widened by one bit so the range check
    // stays meaningful when NUM_STOCKS is a power of two.
    // ------------------------------------------------------------------
    logic [SW:0]   req_id_ext;
    logic          req_id_ok;
    logic [CW-1:0] n_snap;
    logic [AW-1:0] base_snap;

    assign req_id_ext = {1'b0, bus.i_req_stock_id};
    assign req_id_ok  = (req_id_ext < (SW+1)'(NUM_STOCKS));
    assign n_snap     = req_id_ok ? fill_d[bus.i_req_stock_id] : '0;
    assign base_snap  = AW'(BUFFER_SIZE) * AW'(bus.i_req_stock_id);

    // ------------------------------------------------------------------
    // Accumulation datapath. data_vld_q marks the cycle after a read
    // strobe, i.e. when i_rd_data carries a sample of the window.
    // ------------------------------------------------------------------
    logic                      data_vld_q;
    logic [SUM_W-1:0]          acc_sum_q;
    logic [SUM_W-1:0]          acc_sum_d;
    logic [SQ_W-1:0]           acc_sq_q;
    logic [SQ_W-1:0]           acc_sq_d;
    logic [2*DATA_WIDTH-1:0]   data_ext;
    logic [2*DATA_WIDTH-1:0]   data_sq;

    assign data_ext  = {{DATA_WIDTH{1'b0}}, bus.i_rd_data};
    assign data_sq   = data_ext * data_ext;
    assign acc_sum_d = acc_sum_q + (data_vld_q ? SUM_W'(bus.i_rd_data) : '0);
    assign acc_sq_d  = acc_sq_q + (data_vld_q ? SQ_W'(data_sq) : '0);

    // ------------------------------------------------------------------
    // Sweep FSM with registered outputs
    // ------------------------------------------------------------------
    state_t            state_q;
    logic [CW-1:0]     n_q;
    logic [CW-1:0]     k_q;        // offset of the next address to issue
    logic              busy_q;
    logic              rd_en_q;
    logic [AW-1:0]     rd_addr_q;
    logic              done_q;
    logic [CW-1:0]     count_q;
    logic [SUM_W-1:0]  sum_q;
    logic [SQ_W-1:0]   sum_sq_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            k_q        <= '0;
            busy_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            done_q     <= 1'b0;
            count_q    <= '0;
            sum_q      <= '0;
            sum_sq_q   <= '0;
            data_vld_q <= 1'b0;
            acc_sum_q  <= '0;
            acc_sq_q   <= '0;
        end else begin
            data_vld_q <= rd_en_q;
            acc_sum_q  <= acc_sum_d;
            acc_sq_q   <= acc_sq_d;
            done_q     <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (bus.i_req) begin
                        acc_sum_q <= '0;
                        acc_sq_q  <= '0;
                        busy_q    <= 1'b1;
                        if (n_snap == '0) begin
                            // Empty or invalid stock: report immediately
                            n_q      <= '0;
                            done_q   <= 1'b1;
                            count_q  <= '0;
                            sum_q    <= '0;
                            sum_sq_q <= '0;
                            state_q  <= ST_DONE;
                        end else begin
                            n_q       <= n_snap;
                            k_q       <= CW'(1);
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= base_snap;
                            state_q   <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (k_q == n_q) begin
                        rd_en_q <= 1'b0;
                        state_q <= ST_DRAIN;
                    end else begin
                        rd_addr_q <= rd_addr_q + AW'(1);
                        k_q       <= k_q + CW'(1);
                    end
                end
                ST_DRAIN: begin
                    // Last data beat arrives now; publish including it
                    done_q   <= 1'b1;
                    count_q  <= n_q;
                    sum_q    <= acc_sum_d;
                    sum_sq_q <= acc_sq_d;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy    = busy_q;
    assign bus.o_rd_en   = rd_en_q;
    assign bus.o_rd_addr = rd_addr_q;
    assign bus.o_done    = done_q;
    assign bus.o_count   = count_q;
    assign bus.o_sum     = sum_q;
    assign bus.o_sum_sq  = sum_sq_q;
endmodule

// File: tb/tb_volatility_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_volatility_rd_ctrl
// Self-checking bench for volatility_rd_ctrl. A behavioural buffer RAM and a
// reference model (per-stock sample counts, window sums computed by plain
// loops over the stored samples) provide every expected value.
// ---------------------------------------------------------------------------
module tb_volatility_rd_ctrl;
    localparam int NS = 4;
    localparam int BS = 20;
    localparam int DW = 32;
    localparam int SW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    volatility_rd_ctrl_if #(.NUM_STOCKS(NS), .BUFFER_SIZE(BS), .DATA_WIDTH(DW)) bus();

    volatility_rd_ctrl #(.NUM_STOCKS(NS), .BUFFER_SIZE(BS), .DATA_WIDTH(DW)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    // Buffer RAM with 1-cycle read latency
    logic [DW-1:0] mem [NS*BS];
    always @(posedge clk) begin
        if (bus.o_rd_en) bus.i_rd_data <= mem[bus.o_rd_addr];
    end

    int model_fill [NS];
    int wptr [NS];
    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a write for the coming edge and record it in RAM and model
    task automatic note_write(input int s, input logic [DW-1:0] v);
        bus.i_wr_valid    = 1'b1;
        bus.i_wr_stock_id = SW'(s);
        mem[s*BS + wptr[s]] = v;
        wptr[s] = (wptr[s] + 1) % BS;
        if (model_fill[s] < BS) model_fill[s]++;
    endtask

    task automatic do_write(input int s, input logic [DW-1:0] v);
        note_write(s, v);
        @(negedge clk);
        bus.i_wr_valid = 1'b0;
    endtask

    task automatic clear_model();
        for (int s = 0; s < NS; s++) begin
            model_fill[s] = 0;
            wptr[s]       = 0;
        end
    endtask

    // Request one stock window and check the whole transaction
    task automatic run_req(input int s, input bit same_wr, input bit bg,
                           input int drop_c, input int drop_id);
        int n;
        int c;
        int nrd;
        int extra;
        bit seen_done;
        logic [127:0] esum;
        logic [127:0] esq;
        logic [127:0] v;

        if (same_wr) note_write(s, $urandom);
        bus.i_req          = 1'b1;
        bus.i_req_stock_id = SW'(s);
        n    = model_fill[s];
        esum = '0;
        esq  = '0;
        for (int k = 0; k < n; k++) begin
            v    = 128'(mem[s*BS + k]);
            esum = esum + v;
            esq  = esq + v * v;
        end

        @(negedge clk);
        bus.i_req      = 1'b0;
        bus.i_wr_valid = 1'b0;
        c         = 1;
        nrd       = 0;
        seen_done = 1'b0;
        chk("busy_c1", 128'(bus.o_busy), 128'(1));
        while (c <= 60) begin
            if (bus.o_rd_en) begin
                chk($sformatf("addr_s%0d_k%0d", s, nrd), 128'(bus.o_rd_addr), 128'(s*BS + nrd));
                nrd++;
            end
            if (bus.o_done) begin
                seen_done = 1'b1;
                break;
            end
            if (bg && ($urandom_range(0, 1) == 1))
                note_write((s + 1 + int'($urandom_range(0, NS-2))) % NS, $urandom);
            if (c == drop_c) begin
                bus.i_req          = 1'b1;
                bus.i_req_stock_id = SW'(drop_id);
            end
            @(negedge clk);
            c++;
            bus.i_req      = 1'b0;
            bus.i_wr_valid = 1'b0;
        end
        chk("done_seen", 128'(seen_done), 128'(1));
        chk("done_cycle", 128'(c), 128'((n == 0) ? 1 : n + 2));
        chk("rd_beats", 128'(nrd), 128'(n));
        chk("count", 128'(bus.o_count), 128'(n));
        chk("sum", 128'(bus.o_sum), esum);
        chk("sum_sq", 128'(bus.o_sum_sq), esq);
        $display("req stock %0d: n=%0d done@%0d sum=%0h sum_sq=%0h", s, n, c, bus.o_sum, bus.o_sum_sq);

        @(negedge clk);
        chk("busy_after", 128'(bus.o_busy), 128'(0));
        chk("done_pulse", 128'(bus.o_done), 128'(0));
        chk("sum_hold", 128'(bus.o_sum), esum);

        if (drop_c > 0) begin
            extra = 0;
            repeat (25) begin
                @(negedge clk);
                if (bus.o_done) extra++;
            end
            chk("extra_done", 128'(extra), 128'(0));
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_busy"},   128'(bus.o_busy),    128'(0));
        chk({pfx, "_rd_en"},  128'(bus.o_rd_en),   128'(0));
        chk({pfx, "_addr"},   128'(bus.o_rd_addr), 128'(0));
        chk({pfx, "_done"},   128'(bus.o_done),    128'(0));
        chk({pfx, "_count"},  128'(bus.o_count),   128'(0));
        chk({pfx, "_sum"},    128'(bus.o_sum),     128'(0));
        chk({pfx, "_sum_sq"}, 128'(bus.o_sum_sq),  128'(0));
    endtask

    initial begin
        logic [127:0] mx;
        int extra;
        int nw;
        int s;

        bus.i_wr_valid     = 1'b0;
        bus.i_wr_stock_id  = '0;
        bus.i_req          = 1'b0;
        bus.i_req_stock_id = '0;
        for (int i = 0; i < NS*BS; i++) mem[i] = '0;
        clear_model();

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        run_req(0, 1'b0, 1'b0, 0, 0);

        // Basic sweep: 2, 3, 5 in stock 1
        do_write(1, 32'd2);
        do_write(1, 32'd3);
        do_write(1, 32'd5);
        run_req(1, 1'b0, 1'b0, 0, 0);
        chk("basic_sum", 128'(bus.o_sum), 128'(10));
        chk("basic_sq", 128'(bus.o_sum_sq), 128'(38));

        // Saturation: 25 writes to stock 3
        for (int i = 0; i < 25; i++) do_write(3, $urandom);
        run_req(3, 1'b0, 1'b0, 0, 0);

        // Request for stock 2 while stock 1 sweep is busy is dropped
        run_req(1, 1'b0, 1'b0, 2, 2);

        // Max-value window in stock 0
        for (int i = 0; i < 20; i++) do_write(0, 32'hFFFF_FFFF);
        run_req(0, 1'b0, 1'b0, 0, 0);
        mx = 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF;
        chk("max_sum", 128'(bus.o_sum), mx * 128'd20);
        chk("max_sq", 128'(bus.o_sum_sq), mx * mx * 128'd20);

        // Reset during a 3-sample sweep of stock 2
        do_write(2, 32'd7);
        do_write(2, 32'd11);
        do_write(2, 32'd13);
        bus.i_req          = 1'b1;
        bus.i_req_stock_id = SW'(2);
        @(negedge clk);
        bus.i_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        extra = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.o_done) extra++;
        end
        chk_reset_outputs("midrst");
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.o_done) extra++;
        end
        chk("midrst_no_done", 128'(extra), 128'(0));
        clear_model();
        run_req(2, 1'b0, 1'b0, 0, 0);
        run_req(1, 1'b0, 1'b0, 0, 0);

        // Randomized writes and requests, including same-cycle writes and
        // background writes to other stocks during a sweep
        for (int it = 0; it < 30; it++) begin
            nw = int'($urandom_range(0, 8));
            for (int w = 0; w < nw; w++) begin
                s = int'($urandom_range(0, NS-1));
                do_write(s, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom));
            end
            s = int'($urandom_range(0, NS-1));
            run_req(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/volatility_rd_ctrl.md
# volatility_rd_ctrl

Read-side controller for the per-stock volatility buffer. It tracks how many valid samples each stock holds by observing the write stream, and on request sweeps that stock's buffer region through a 1-cycle-latency synchronous RAM port. It accumulates the sum and the sum of squares of the window, which downstream volatility (variance) arithmetic consumes. It sits between the volatility buffer RAM read port and the volatility compute stage.

## Interface
- NUM_STOCKS, 4, number of stocks; stock s owns RAM addresses BUFFER_SIZE*s .. BUFFER_SIZE*s+BUFFER_SIZE-1
- BUFFER_SIZE, 20, samples per stock region
- DATA_WIDTH, 32, unsigned sample width
- CW = $clog2(BUFFER_SIZE+1) (localparam), count width

Ports:
- i_clk  in  1  clock; all logic on posedge
- i_reset_n  in  1  reset, synchronous, active-low
- i_wr_valid  in  1  a sample was written to the buffer this cycle
- i_wr_stock_id  in  $clog2(NUM_STOCKS)  stock of that write
- i_req  in  1  single-cycle request to read one stock window
- i_req_stock_id  in  $clog2(NUM_STOCKS)  stock to read
- o_busy  out  1  high from the cycle after an accepted request through the o_done cycle
- o_rd_en  out  1  RAM read strobe
- o_rd_addr  out  $clog2(NUM_STOCKS*BUFFER_SIZE)  RAM read address
- i_rd_data  in  DATA_WIDTH  RAM data; valid the cycle after o_rd_en
- o_done  out  1  one-cycle pulse; results valid
- o_count  out  CW  samples accumulated
- o_sum  out  DATA_WIDTH+CW  sum of samples
- o_sum_sq  out  2*DATA_WIDTH+CW  sum of squared samples

## Operation
- Fill tracking: per-stock counter fill[s], CW bits.
  - Increments on i_wr_valid for stock i_wr_stock_id.
  - Saturates at BUFFER_SIZE.
  - A write with an id >= NUM_STOCKS is ignored.
- Sample order within the window does not matter, so reads always cover offsets 0..fill-1 of the region.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: i_req accepted only here.
    - On accept: latch base = BUFFER_SIZE*i_req_stock_id and n = fill[id] (snapshot, including a same-cycle write to that stock). Clear the accumulators.
    - If n == 0 or id >= NUM_STOCKS, go to DONE with n forced to 0. Otherwise go to READ.
  - READ: o_rd_en=1, o_rd_addr=base+k for k=0..n-1, one per cycle. After k=n-1, go to DRAIN.
  - Accumulation: every cycle whose previous cycle had o_rd_en=1, sum += i_rd_data and sum_sq += i_rd_data*i_rd_data (full-width unsigned product, zero-extended).
  - DRAIN: no read; absorbs the last data beat; go to DONE.
  - DONE: o_done=1 for one cycle; o_count=n; go to IDLE.
- i_req while o_busy=1 is dropped, not queued.
- o_sum, o_sum_sq and o_count update only in the DONE cycle and hold until the next DONE.
- Widths are sized so BUFFER_SIZE samples of the maximum value (2^DATA_WIDTH-1) cannot overflow.
- Writes continue to update fill[] during a read. Data coherency of entries overwritten mid-sweep is the writer's responsibility. The snapshot n is unaffected by those writes.
- Reset:
  - All fill[] = 0; FSM to IDLE.
  - o_busy, o_rd_en, o_done = 0; o_rd_addr = 0; o_count, o_sum, o_sum_sq = 0.
  - Reset mid-sweep aborts the sweep with no o_done pulse.

## Timing
- Request accepted at cycle 0 (IDLE, i_req=1).
- Non-empty window of n samples:
  - o_busy=1 cycles 1..n+2.
  - o_rd_en=1 cycles 1..n.
  - Data captured cycles 2..n+1.
  - o_done in cycle n+2.
  - Next request is accepted at cycle n+3 at the earliest.
- Empty window: o_busy=1 and o_done=1 in cycle 1 only; next request accepted in cycle 2.
- o_rd_addr holds its last value when o_rd_en=0.
- Throughput: one sample per cycle during READ.

## Test plan
- Reset check: with i_reset_n=0 for 2 cycles, all outputs are 0. A request for stock 0 then gives o_done at cycle 1 with count 0, sum 0, sum_sq 0.
- Basic sweep: write 2, 3, 5 to stock 1, then request stock 1 -> o_rd_addr 20, 21, 22 on cycles 1-3; o_done at cycle 5 with count 3, sum 10, sum_sq 38.
- Saturation: 25 writes to stock 3, then request -> addresses 60..79; count 20; o_done at cycle 22.
- Busy drop: i_req for stock 2 at cycle 2 of a stock 1 sweep -> ignored; exactly one o_done; results reflect stock 1 only.
- Max-value overflow: 20 samples of 0xFFFFFFFF in stock 0 -> sum 20*(2^32-1), sum_sq 20*(2^32-1)^2, both exact.
- Reset mid-sweep: assert reset at cycle 2 of a 3-sample sweep -> no o_done; fill[] cleared; a following request returns count 0.
